// File: rtl/parsing_bram_loader.sv
// -----------------------------------------------------------------------------
// parsing_bram_loader
//
// Purpose:
//   Upstream feeder for the parsing stage. Accepts a valid/ready stream of
//   DW-bit words and writes them bank-major into NUM_BANK input BRAM banks
//   (DEPTH words per bank) through the parsing stage's write port. Once the
//   last word is written, it waits GAP cycles. It then raises a level start
//   flag that stays high until the next load request.
//
// Ports:
//   clk     in   system clock, all logic on the rising edge
//   rst     in   synchronous reset, active-high
//   iLoad   in   single-cycle request to begin a full load (IDLE or DONE only)
//   iValid  in   input word valid
//   oReady  out  loader can accept a word (state == LOAD)
//   iData   in   input word
//   oEna    out  one-hot bank enable, pulsed for one cycle per accepted word
//   oWea    out  one-hot bank write enable, identical to oEna
//   oAddra  out  write address within the selected bank
//   oDia    out  write data
//   oStart  out  level start to the parsing stage
//   oBusy   out  high while in LOAD or GAP
// -----------------------------------------------------------------------------
module parsing_bram_loader #(
  parameter int NUM_BANK = 16,
  parameter int DEPTH    = 128,
  parameter int AW       = 9,
  parameter int DW       = 128,
  parameter int GAP      = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iLoad,
  input  logic                iValid,
  output logic                oReady,
  input  logic [DW-1:0]       iData,
  output logic [NUM_BANK-1:0] oEna,
  output logic [NUM_BANK-1:0] oWea,
  output logic [AW-1:0]       oAddra,
  output logic [DW-1:0]       oDia,
  output logic                oStart,
  output logic                oBusy
);

  // Counter widths. Guards keep the widths at one bit or more for degenerate sizes.
  localparam int BW = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
  localparam int CW = (DEPTH > 1)    ? $clog2(DEPTH)    : 1;
  localparam int GW = (GAP > 1)      ? $clog2(GAP)      : 1;

  localparam logic [BW-1:0]       LAST_BANK = BW'(NUM_BANK - 1);
  localparam logic [CW-1:0]       LAST_ADDR = CW'(DEPTH - 1);
  localparam logic [GW-1:0]       LAST_GAP  = GW'(GAP - 1);
  localparam logic [NUM_BANK-1:0] BANK0_SEL = NUM_BANK'(1'b1);
  localparam logic [BW-1:0]       BANK_INC  = BW'(1'b1);
  localparam logic [CW-1:0]       ADDR_INC  = CW'(1'b1);
  localparam logic [GW-1:0]       GAP_INC   = GW'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [BW-1:0]         r_bank;
  logic [CW-1:0]         r_addr;
  logic [GW-1:0]         r_gap;
  logic [NUM_BANK-1:0]   r_ena;
  logic [AW-1:0]         r_addra;
  logic [DW-1:0]         r_dia;
  logic                  r_start;
  logic                  r_ready;
  logic                  r_busy;

  logic                  w_accept;
  logic                  w_last_addr;
  logic                  w_last_bank;
  logic [NUM_BANK-1:0]   w_bank_sel;

  // r_ready mirrors (state == LOAD), so a handshake can only happen in LOAD.
  assign w_accept    = iValid & r_ready;
  assign w_last_addr = (r_addr == LAST_ADDR);
  assign w_last_bank = (r_bank == LAST_BANK);
  // r_bank never exceeds LAST_BANK, so this shift always stays inside the vector.
  assign w_bank_sel  = BANK0_SEL << r_bank;

  // Loader FSM with counters and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_bank  <= '0;
      r_addr  <= '0;
      r_gap   <= '0;
      r_ena   <= '0;
      r_addra <= '0;
      r_dia   <= '0;
      r_start <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      // The write strobe is a single-cycle pulse unless a word is accepted.
      // The address and data registers keep their last values.
      r_ena <= '0;
      case (r_state)
        ST_IDLE: begin
          if (iLoad) begin
            r_state <= ST_LOAD;
            r_bank  <= '0;
            r_addr  <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
          end
        end

        ST_LOAD: begin
          // iLoad is deliberately ignored here: a running load cannot restart.
          if (w_accept) begin
            r_ena   <= w_bank_sel;
            r_addra <= AW'(r_addr);
            r_dia   <= iData;
            if (w_last_addr) begin
              r_addr <= '0;
              if (w_last_bank) begin
                // The final word is accepted. oReady drops from the next cycle.
                r_state <= ST_GAP;
                r_gap   <= '0;
                r_ready <= 1'b0;
              end else begin
                r_bank <= r_bank + BANK_INC;
              end
            end else begin
              r_addr <= r_addr + ADDR_INC;
            end
          end
        end

        ST_GAP: begin
          // The gap counter runs 0..GAP-1. oStart rises on the edge that leaves GAP.
          // That edge comes GAP cycles after the final write pulse.
          if (r_gap == LAST_GAP) begin
            r_state <= ST_DONE;
            r_start <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_gap <= r_gap + GAP_INC;
          end
        end

        ST_DONE: begin
          if (iLoad) begin
            r_state <= ST_LOAD;
            r_bank  <= '0;
            r_addr  <= '0;
            r_start <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
          end
        end

        default: begin
          // Recover from an illegal state encoding to a quiet IDLE.
          r_state <= ST_IDLE;
          r_bank  <= '0;
          r_addr  <= '0;
          r_gap   <= '0;
          r_start <= 1'b0;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign oReady = r_ready;
  assign oBusy  = r_busy;
  assign oEna   = r_ena;
  assign oWea   = r_ena;
  assign oAddra = r_addra;
  assign oDia   = r_dia;
  assign oStart = r_start;

endmodule

// File: doc/parsing_bram_loader.md
Name: parsing_bram_loader

Overview:
- Upstream feeder for the parsing stage.
- Accepts a valid/ready stream of 128-bit words and writes them, bank-major, into the 16 input BRAM banks of the parsing stage through its write port (ena/wea/addra/dia).
- After a programmable quiet gap it raises a level start flag that drives the parsing stage's iStart.
- Replaces hand-driven bank initialisation with a hardware loader.

Parameters:
NUM_BANK, 16, number of BRAM banks (one-hot enable width)
DEPTH, 128, words written per bank
AW, 9, write address width
DW, 128, write data width
GAP, 10, idle cycles between last write and start assertion (must be >= 1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
iLoad  input  1  single-cycle request to begin a full load
iValid  input  1  input word valid
oReady  output  1  loader can accept a word
iData  input  DW  input word
oEna  output  NUM_BANK  one-hot bank enable to parsing stage write port
oWea  output  NUM_BANK  one-hot bank write enable (identical to oEna)
oAddra  output  AW  write address within selected bank
oDia  output  DW  write data
oStart  output  1  level start to parsing stage
oBusy  output  1  high in LOAD or GAP

Behaviour:
- Reset (rst=1 at an edge): state IDLE, bank/addr/gap counters 0. All outputs 0, including oEna, oWea, oAddra, oDia, oStart, oReady and oBusy. Reset mid-load abandons the load; no write pulse follows.
- States: IDLE, LOAD, GAP, DONE. oReady = (state==LOAD); oBusy = (state==LOAD || state==GAP); both decode registered state.
- IDLE: iLoad=1 -> LOAD, bank=0, addr=0.
- LOAD, accept = iValid && oReady. Signals at the next edge after an accept:
  - oEna = oWea = 1<<bank
  - oAddra = addr (zero-extended to AW)
  - oDia = iData
  - The write pulse lasts exactly 1 cycle, 1-cycle latency.
- LOAD, non-accept cycle: oEna = oWea = 0; oAddra and oDia hold their last values.
- LOAD, counter advance on each accept:
  - If addr==DEPTH-1: addr=0, bank=bank+1.
  - Otherwise addr=addr+1.
- LOAD, end of load: an accept at bank==NUM_BANK-1 and addr==DEPTH-1 moves to GAP with gap counter 0, so oReady is low from the next cycle. Total accepts per load = NUM_BANK*DEPTH (2048 default).
- GAP: the gap counter increments each cycle. When it reaches GAP-1 -> DONE, and oStart=1 registered in the same edge. oStart therefore rises GAP cycles after the last write pulse becomes visible.
- DONE: oStart held high, oReady=0, oEna=oWea=0. iLoad=1 -> LOAD with bank=0 and addr=0, and oStart=0 at that same edge.
- iLoad in LOAD or GAP is ignored (no restart, counters unaffected).
- iValid with iData while not in LOAD is ignored; no write occurs.
- oEna is always one-hot or zero. It never selects a bank >= NUM_BANK.

Test Plan:
- Full load, no backpressure: iLoad pulse, then 2048 consecutive valid words with iData = {bank, addr} pattern (e.g. bank 3, addr 5 -> 128'h0305).
  - oEna/oWea walk 16'h0001..16'h8000, oAddra 0..127 per bank, oDia matches with 1-cycle latency.
  - oStart rises exactly 10 cycles after the final write pulse (oEna=16'h8000, oAddra=127).
- Bubbled input: iValid toggled pseudo-randomly.
  - Write pulses occur only on accepted words, with no address skips or duplicates.
  - oEna=0 on idle cycles; final contents are identical to the first scenario.
- Bank boundary: observe the 128th and 129th accepts. They must produce (oEna=16'h0001, oAddra=127) then (oEna=16'h0002, oAddra=0).
- iLoad asserted mid-LOAD at word 500: no restart, and word 501 is written to bank 3 addr 117.
- Reset mid-load at word 300:
  - Every output is 0 the next cycle and state is IDLE.
  - A new iLoad restarts at bank 0 addr 0.
- Reload from DONE: iLoad while oStart=1.
  - oStart drops the next cycle and oReady rises.
  - A second full load completes and oStart re-asserts after GAP.
